// File: rtl/btn_conditioner.sv
// btn_conditioner
// Conditions the four Nexys direction buttons (U, D, L, R) for the game logic.
// Each button runs through its own lane: a two-flop synchroniser into the
// ClkPort domain, then a debounce / auto-repeat FSM with one shared-width
// counter. Lanes are fully independent; nothing is shared between them.
//
// Per lane outputs (all registered, no combinational path from btn_raw):
//   btn_db     clean level; high from the PRESS cycle until the release
//              has been stable for DEBOUNCE_CYCLES.
//   btn_pulse  one ClkPort cycle on every accepted press.
//   btn_repeat one cycle on the press, then after REPEAT_DELAY+1 cycles,
//              then every REPEAT_PERIOD cycles while the button is held.
//
// Lane FSM state is held in gen_lane[i].state_q (lane_state_t) for
// hierarchical observation.
//
// Handshake note: this block has no valid/ready interface. btn_pulse and
// btn_repeat are single-cycle strobes with no back-pressure; a consumer must
// sample them every ClkPort cycle. btn_db is a plain level.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 26
) (
  input  logic       ClkPort,
  input  logic       Reset,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_db,
  output logic [3:0] btn_pulse,
  output logic [3:0] btn_repeat
);

  // Terminal counts, sized to the counter so all compares are width-matched.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_PRESS    = 3'd2,
    ST_HOLD_DLY = 3'd3,
    ST_HOLD_RPT = 3'd4,
    ST_REL      = 3'd5
  } lane_state_t;

  // Two-flop synchroniser; sync2_q is the lane FSM input.
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  // Bring the asynchronous button inputs into the ClkPort domain.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : gen_lane
    lane_state_t      state_q;
    lane_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rpt_d;
    logic             db_q;
    logic             pulse_q;
    logic             repeat_q;
    logic             s;

    assign s = sync2_q[i];

    // Lane state and counter registers.
    always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= CNT_ZERO;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next-state and counter logic. rpt_d flags a repeat-interval expiry so
    // the repeat strobe lands in the cycle after the terminal count.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rpt_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_d = CNT_ZERO;
          if (s) begin
            state_d = ST_ARM;
          end
        end
        ST_ARM: begin
          if (!s) begin
            // Too short to be a press: drop it silently.
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == DB_LAST) begin
            state_d = ST_PRESS;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_PRESS: begin
          state_d = ST_HOLD_DLY;
          cnt_d   = CNT_ZERO;
        end
        ST_HOLD_DLY: begin
          if (!s) begin
            state_d = ST_REL;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == DLY_LAST) begin
            state_d = ST_HOLD_RPT;
            cnt_d   = CNT_ZERO;
            rpt_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HOLD_RPT: begin
          if (!s) begin
            state_d = ST_REL;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == PER_LAST) begin
            cnt_d = CNT_ZERO;
            rpt_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_REL: begin
          if (s) begin
            // Release bounce: treat as still held and restart the repeat
            // delay, with no new press or repeat strobe.
            state_d = ST_HOLD_DLY;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == DB_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          // Unused encodings recover to IDLE.
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    // Registered outputs, decoded from the next state so they line up with
    // the state register rather than lagging it by a cycle.
    always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
        db_q     <= 1'b0;
        pulse_q  <= 1'b0;
        repeat_q <= 1'b0;
      end else begin
        db_q     <= (state_d == ST_PRESS) || (state_d == ST_HOLD_DLY) ||
                    (state_d == ST_HOLD_RPT) || (state_d == ST_REL);
        pulse_q  <= (state_d == ST_PRESS);
        repeat_q <= (state_d == ST_PRESS) || rpt_d;
      end
    end

    assign btn_db[i]     = db_q;
    assign btn_pulse[i]  = pulse_q;
    assign btn_repeat[i] = repeat_q;

    // Strobes are single-cycle by construction; flag any back-to-back pair.
    a_pulse_single : assert property (@(posedge ClkPort) disable iff (Reset)
      !(pulse_q && $past(pulse_q)));
    a_repeat_single : assert property (@(posedge ClkPort) disable iff (Reset)
      !(repeat_q && $past(repeat_q)));
    a_pulse_implies_db : assert property (@(posedge ClkPort) disable iff (Reset)
      !(pulse_q && !db_q));
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner with small timing parameters.
// Stimulus pushes expected strobe events {cycle, pulse, repeat} into exp_q;
// a monitor pops and compares whenever the DUT raises any strobe.
// Level (btn_db) checks are made directly at hand-computed cycles.
module tb_btn_conditioner;

  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int PER = 8;
  localparam int W   = 40;

  logic       ClkPort;
  logic       Reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_db;
  logic [3:0] btn_pulse;
  logic [3:0] btn_repeat;

  int cyc;
  int checks;
  int errors;
  logic [W-1:0] exp_q[$];

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER),
    .CNT_W          (5)
  ) dut (
    .ClkPort   (ClkPort),
    .Reset     (Reset),
    .btn_raw   (btn_raw),
    .btn_db    (btn_db),
    .btn_pulse (btn_pulse),
    .btn_repeat(btn_repeat)
  );

  // Clock and cycle counter: cyc equals the index of the most recent edge.
  initial ClkPort = 1'b0;
  always #5 ClkPort = ~ClkPort;
  initial cyc = 0;
  always @(posedge ClkPort) cyc <= cyc + 1;

  // Watchdog.
  always @(negedge ClkPort) begin
    if (cyc > 5000) begin
      $display("FAIL watchdog: cycle %0d exceeded limit 5000", cyc);
      $fatal(1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge ClkPort);
  endtask

  task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r);
    exp_q.push_back({c[31:0], p, r});
  endtask

  // Monitor: every strobe observed must match the next expected event.
  always @(negedge ClkPort) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (!Reset && ((btn_pulse | btn_repeat) != 4'b0000)) begin
      got = {cyc[31:0], btn_pulse, btn_repeat};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: cycle %0d pulse %b repeat %b, none expected",
                 cyc, btn_pulse, btn_repeat);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL strobe_event: got cycle %0d pulse %b repeat %b, expected cycle %0d pulse %b repeat %b",
                   got[39:8], got[7:4], got[3:0], exp[39:8], exp[7:4], exp[3:0]);
        end
      end
    end
  end

  initial begin
    int s0;
    int p;
    int r0;
    int f;
    int d;
    logic glitch_bad;

    checks  = 0;
    errors  = 0;
    Reset   = 1'b1;
    btn_raw = 4'b0000;
    repeat (3) @(negedge ClkPort);
    check("reset_db", {28'd0, btn_db}, 32'd0);
    check("reset_pulse_repeat", {24'd0, btn_pulse, btn_repeat}, 32'd0);
    Reset = 1'b0;
    repeat (3) @(negedge ClkPort);

    // Clean press on lane 0, release before the first repeat.
    s0 = cyc + 1;
    btn_raw[0] = 1'b1;
    p = s0 + DB + 2;
    push_ev(p, 4'b0001, 4'b0001);
    wait_until(p - 1);
    check("press_db_before", {31'd0, btn_db[0]}, 32'd0);
    wait_until(p);
    check("press_db_rise", {31'd0, btn_db[0]}, 32'd1);
    wait_until(p + 6);
    btn_raw[0] = 1'b0;
    r0 = cyc + 1;
    wait_until(r0 + DB + 1);
    check("release_db_held", {31'd0, btn_db[0]}, 32'd1);
    wait_until(r0 + DB + 2);
    check("release_db_fall", {31'd0, btn_db[0]}, 32'd0);
    repeat (4) @(negedge ClkPort);

    // Glitch on lane 1: three raw-high cycles are not enough.
    btn_raw[1] = 1'b1;
    repeat (3) @(negedge ClkPort);
    btn_raw[1] = 1'b0;
    glitch_bad = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge ClkPort);
      if (btn_db != 4'b0000) glitch_bad = 1'b1;
    end
    check("glitch_db_quiet", {31'd0, glitch_bad}, 32'd0);

    // Auto-repeat on lane 2, held 60 cycles.
    s0 = cyc + 1;
    btn_raw[2] = 1'b1;
    p = s0 + DB + 2;
    push_ev(p, 4'b0100, 4'b0100);
    push_ev(p + 21, 4'b0000, 4'b0100);
    push_ev(p + 29, 4'b0000, 4'b0100);
    push_ev(p + 37, 4'b0000, 4'b0100);
    push_ev(p + 45, 4'b0000, 4'b0100);
    push_ev(p + 53, 4'b0000, 4'b0100);
    repeat (60) @(negedge ClkPort);
    btn_raw[2] = 1'b0;
    r0 = cyc + 1;
    wait_until(r0 + DB + 1);
    check("rpt_release_db_held", {31'd0, btn_db[2]}, 32'd1);
    wait_until(r0 + DB + 2);
    check("rpt_release_db_fall", {31'd0, btn_db[2]}, 32'd0);
    repeat (4) @(negedge ClkPort);

    // Release bounce on lane 3: low 2, high 1, then low.
    s0 = cyc + 1;
    btn_raw[3] = 1'b1;
    p = s0 + DB + 2;
    push_ev(p, 4'b1000, 4'b1000);
    wait_until(p + 3);
    btn_raw[3] = 1'b0;
    @(negedge ClkPort);
    @(negedge ClkPort);
    btn_raw[3] = 1'b1;
    @(negedge ClkPort);
    btn_raw[3] = 1'b0;
    f = cyc + 1;
    wait_until(f + DB + 1);
    check("bounce_db_held", {31'd0, btn_db[3]}, 32'd1);
    wait_until(f + DB + 2);
    check("bounce_db_fall", {31'd0, btn_db[3]}, 32'd0);
    repeat (4) @(negedge ClkPort);

    // All four together, then reset in the middle of auto-repeat.
    s0 = cyc + 1;
    btn_raw = 4'b1111;
    p = s0 + DB + 2;
    push_ev(p, 4'b1111, 4'b1111);
    push_ev(p + 21, 4'b0000, 4'b1111);
    push_ev(p + 29, 4'b0000, 4'b1111);
    wait_until(p);
    check("all_db_rise", {28'd0, btn_db}, 32'hf);
    wait_until(p + 32);
    #1 Reset = 1'b1;
    #1;
    check("midreset_db", {28'd0, btn_db}, 32'd0);
    check("midreset_strobes", {24'd0, btn_pulse, btn_repeat}, 32'd0);
    repeat (3) @(negedge ClkPort);
    Reset = 1'b0;
    d = cyc;
    push_ev(d + DB + 3, 4'b1111, 4'b1111);
    wait_until(d + DB + 2);
    check("post_reset_db_before", {28'd0, btn_db}, 32'd0);
    wait_until(d + DB + 3);
    check("post_reset_db_rise", {28'd0, btn_db}, 32'hf);
    repeat (5) @(negedge ClkPort);
    btn_raw = 4'b0000;
    repeat (20) @(negedge ClkPort);
    check("final_db", {28'd0, btn_db}, 32'd0);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
